// File: rtl/xt_lb_arbiter_if.sv
// xt_lb_arbiter_if: requester and bridge signals of the low-speed bus arbiter.
interface xt_lb_arbiter_if #(
   parameter int REQ_NUM = 3,
   parameter int ADDR_W  = 8
);
   logic [REQ_NUM-1:0]             req_ren;
   logic [REQ_NUM-1:0]             req_wen;
   logic [REQ_NUM-1:0][ADDR_W-1:0] req_raddr;
   logic [REQ_NUM-1:0][ADDR_W-1:0] req_waddr;
   logic [REQ_NUM-1:0][31:0]       req_wdata;
   logic [REQ_NUM-1:0][1:0]        req_wwidth;
   logic [REQ_NUM-1:0]             req_ack;
   logic [31:0]                    req_rdata;
   logic                           req_err;
   logic                           br_ren;
   logic                           br_wen;
   logic [ADDR_W-1:0]              br_raddr;
   logic [ADDR_W-1:0]              br_waddr;
   logic [31:0]                    br_wdata;
   logic [1:0]                     br_wwidth;
   logic [31:0]                    br_rdata;
   logic                           br_idle;
   modport slave (
      input  req_ren, req_wen, req_raddr, req_waddr, req_wdata, req_wwidth, br_rdata, br_idle,
      output req_ack, req_rdata, req_err, br_ren, br_wen, br_raddr, br_waddr, br_wdata, br_wwidth
   );
   modport master (
      output req_ren, req_wen, req_raddr, req_waddr, req_wdata, req_wwidth, br_rdata, br_idle,
      input  req_ack, req_rdata, req_err, br_ren, br_wen, br_raddr, br_waddr, br_wdata, br_wwidth
   );
endinterface

// File: rtl/xt_lb_arbiter.sv
// xt_lb_arbiter: round-robin arbiter serialising requesters onto one low-speed bridge.
// Define XT_LB_ARB_TIMEOUT_EN to add the bridge watchdog (req_err on expiry).
module xt_lb_arbiter #(
   parameter int REQ_NUM = 3,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input logic               hb_clk,
   input logic               rst,
   xt_lb_arbiter_if.slave    bus_io
);
   localparam int PW = $clog2(REQ_NUM);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_e;
   state_e             st_q;
   logic [PW-1:0]      rr_q, gnt_q, gnt_d;
   logic [REQ_NUM-1:0] pend, ack_q;
   logic [31:0]        rdata_q, wdata_q;
   logic               ren_q, wen_q;
   logic [ADDR_W-1:0]  raddr_q, waddr_q;
   logic [1:0]         wwidth_q;
   logic               done, tmo, to_hit;
   int                 j;
   assign pend = bus_io.req_ren | bus_io.req_wen;
   assign done = st_q == WAIT_DONE && bus_io.br_idle;
   assign tmo  = to_hit && !done;
   // Descending scan so the pending index closest after rr_q wins last.
   always_comb begin
      gnt_d = '0;
      j = 0;
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
         j = int'(rr_q) + k;
         j = j >= REQ_NUM ? j - REQ_NUM : j;
         gnt_d = pend[j] ? PW'(j) : gnt_d;
      end
   end
   always_ff @(posedge hb_clk or posedge rst) begin
      if (rst) begin
         st_q     <= IDLE;
         rr_q     <= '0;
         gnt_q    <= '0;
         ack_q    <= '0;
         rdata_q  <= '0;
         ren_q    <= 1'b0;
         wen_q    <= 1'b0;
         raddr_q  <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         wwidth_q <= '0;
      end else begin
         ack_q <= '0;
         ren_q <= 1'b0;
         wen_q <= 1'b0;
         case (st_q)
            IDLE: if (bus_io.br_idle && |pend) begin
               gnt_q    <= gnt_d;
               ren_q    <= bus_io.req_ren[gnt_d];
               wen_q    <= bus_io.req_wen[gnt_d];
               raddr_q  <= bus_io.req_raddr[gnt_d];
               waddr_q  <= bus_io.req_waddr[gnt_d];
               wdata_q  <= bus_io.req_wdata[gnt_d];
               wwidth_q <= bus_io.req_wwidth[gnt_d];
               st_q     <= ISSUE;
            end
            ISSUE:     st_q <= WAIT_BUSY;
            WAIT_BUSY: st_q <= tmo ? RESP : bus_io.br_idle ? WAIT_BUSY : WAIT_DONE;
            WAIT_DONE: st_q <= done || tmo ? RESP : WAIT_DONE;
            RESP: begin
               rr_q <= gnt_q == PW'(REQ_NUM - 1) ? '0 : gnt_q + PW'(1);
               st_q <= IDLE;
            end
            default:   st_q <= IDLE;
         endcase
         if (done || tmo) begin
            rdata_q <= tmo ? '0 : bus_io.br_rdata;
            ack_q   <= REQ_NUM'(1) << gnt_q;
         end
      end
   end
`ifdef XT_LB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q;
   logic          err_q;
   // Counter is 0 in ISSUE, so expiry lands the ack TIMEOUT cycles after ISSUE.
   assign to_hit = (st_q == WAIT_BUSY || st_q == WAIT_DONE) && cnt_q == CW'(TIMEOUT - 1);
   always_ff @(posedge hb_clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= st_q == ISSUE || st_q == WAIT_BUSY || st_q == WAIT_DONE ? cnt_q + CW'(1) : '0;
         if (done || tmo) err_q <= tmo;
      end
   end
   assign bus_io.req_err = err_q;
`else
   assign to_hit = 1'b0;
   assign bus_io.req_err = 1'b0;
`endif
   assign bus_io.req_ack   = ack_q;
   assign bus_io.req_rdata = rdata_q;
   assign bus_io.br_ren    = ren_q;
   assign bus_io.br_wen    = wen_q;
   assign bus_io.br_raddr  = raddr_q;
   assign bus_io.br_waddr  = waddr_q;
   assign bus_io.br_wdata  = wdata_q;
   assign bus_io.br_wwidth = wwidth_q;
endmodule

// File: tb/tb_xt_lb_arbiter.sv
// tb_xt_lb_arbiter: directed checks of grant order, latency, reset abort and timeout.
module tb_xt_lb_arbiter;
   logic hb_clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   xt_lb_arbiter_if #(.REQ_NUM(3), .ADDR_W(8)) bus ();
   xt_lb_arbiter #(.REQ_NUM(3), .ADDR_W(8), .TIMEOUT(10)) dut (
      .hb_clk (hb_clk),
      .rst    (rst),
      .bus_io (bus)
   );
   always #5 hb_clk = ~hb_clk;

   task automatic clear_reqs();
      bus.req_ren    = '0;
      bus.req_wen    = '0;
      bus.req_raddr  = '0;
      bus.req_waddr  = '0;
      bus.req_wdata  = '0;
      bus.req_wwidth = '0;
   endtask

   task automatic wait_issue(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge hb_clk);
         ok = bus.br_ren | bus.br_wen;
      end
   endtask

   // Called at the negedge of the ISSUE cycle; returns at the negedge of the ack cycle.
   task automatic run_bridge(input int b, input logic [31:0] d);
      bus.br_idle = 1'b0;
      repeat (b + 1) @(negedge hb_clk);
      bus.br_idle  = 1'b1;
      bus.br_rdata = d;
      @(negedge hb_clk);
   endtask

   task automatic test_reset();
      clear_reqs();
      bus.br_idle  = 1'b1;
      bus.br_rdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge hb_clk);
      vectors++;
      if ({bus.req_ack, bus.req_err, bus.br_ren, bus.br_wen} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_ctl got %b exp 000000", {bus.req_ack, bus.req_err, bus.br_ren, bus.br_wen});
      end
      vectors++;
      if ({bus.req_rdata, bus.br_wdata, bus.br_raddr, bus.br_waddr, bus.br_wwidth} !== 82'b0) begin
         miscompares++;
         $display("FAIL reset_data got %h exp 0", {bus.req_rdata, bus.br_wdata, bus.br_raddr, bus.br_waddr, bus.br_wwidth});
      end
      rst = 1'b0;
      @(negedge hb_clk);
   endtask

   task automatic test_single_read();
      bus.req_ren[0]   = 1'b1;
      bus.req_raddr[0] = 8'h12;
      @(negedge hb_clk);
      vectors++;
      if ({bus.br_ren, bus.br_wen, bus.br_raddr} !== {2'b10, 8'h12}) begin
         miscompares++;
         $display("FAIL rd_issue got %b/%b/%h exp 1/0/12", bus.br_ren, bus.br_wen, bus.br_raddr);
      end
      bus.br_idle = 1'b0;
      @(negedge hb_clk);
      vectors++;
      if (bus.br_ren !== 1'b0) begin
         miscompares++;
         $display("FAIL rd_ren_pulse got %b exp 0", bus.br_ren);
      end
      @(negedge hb_clk);
      vectors++;
      if (bus.req_ack !== 3'b000) begin
         miscompares++;
         $display("FAIL rd_early_ack got %b exp 000", bus.req_ack);
      end
      bus.br_idle  = 1'b1;
      bus.br_rdata = 32'hA5A5_0001;
      @(negedge hb_clk);
      vectors++;
      if ({bus.req_ack, bus.req_err, bus.req_rdata} !== {3'b001, 1'b0, 32'hA5A5_0001}) begin
         miscompares++;
         $display("FAIL rd_ack got %b/%b/%h exp 001/0/a5a50001", bus.req_ack, bus.req_err, bus.req_rdata);
      end
      clear_reqs();
      @(negedge hb_clk);
      vectors++;
      if (bus.req_ack !== 3'b000) begin
         miscompares++;
         $display("FAIL rd_ack_pulse got %b exp 000", bus.req_ack);
      end
   endtask

   task automatic test_read_write();
      bus.req_ren[1]    = 1'b1;
      bus.req_wen[1]    = 1'b1;
      bus.req_raddr[1]  = 8'h21;
      bus.req_waddr[1]  = 8'h20;
      bus.req_wdata[1]  = 32'h55;
      bus.req_wwidth[1] = 2'd2;
      @(negedge hb_clk);
      vectors++;
      if ({bus.br_ren, bus.br_wen, bus.br_raddr, bus.br_waddr, bus.br_wdata, bus.br_wwidth}
          !== {2'b11, 8'h21, 8'h20, 32'h55, 2'd2}) begin
         miscompares++;
         $display("FAIL rw_issue got %b%b/%h/%h/%h/%0d exp 11/21/20/00000055/2",
                  bus.br_ren, bus.br_wen, bus.br_raddr, bus.br_waddr, bus.br_wdata, bus.br_wwidth);
      end
      bus.br_idle = 1'b0;
      @(negedge hb_clk);
      vectors++;
      if ({bus.br_ren, bus.br_wen, bus.br_waddr} !== {2'b00, 8'h20}) begin
         miscompares++;
         $display("FAIL rw_one_issue got %b%b/%h exp 00/20", bus.br_ren, bus.br_wen, bus.br_waddr);
      end
      @(negedge hb_clk);
      bus.br_idle  = 1'b1;
      bus.br_rdata = 32'h0000_0077;
      @(negedge hb_clk);
      vectors++;
      if ({bus.req_ack, bus.req_rdata, bus.br_wdata} !== {3'b010, 32'h77, 32'h55}) begin
         miscompares++;
         $display("FAIL rw_ack got %b/%h/%h exp 010/00000077/00000055", bus.req_ack, bus.req_rdata, bus.br_wdata);
      end
      clear_reqs();
      for (int i = 0; i < 4; i++) begin
         @(negedge hb_clk);
         vectors++;
         if ({bus.req_ack, bus.br_ren, bus.br_wen} !== 5'b0) begin
            miscompares++;
            $display("FAIL rw_single_ack cyc %0d got %b exp 00000", i, {bus.req_ack, bus.br_ren, bus.br_wen});
         end
      end
   endtask

   task automatic test_pending_bridge();
      bit ok;
      bus.br_idle      = 1'b0;
      bus.req_ren[2]   = 1'b1;
      bus.req_raddr[2] = 8'h44;
      for (int i = 0; i < 5; i++) begin
         @(negedge hb_clk);
         vectors++;
         if ({bus.br_ren, bus.br_wen} !== 2'b00) begin
            miscompares++;
            $display("FAIL pend_hold cyc %0d got %b%b exp 00", i, bus.br_ren, bus.br_wen);
         end
      end
      bus.br_idle = 1'b1;
      @(negedge hb_clk);
      ok = bus.br_ren;
      vectors++;
      if (!ok || bus.br_raddr !== 8'h44) begin
         miscompares++;
         $display("FAIL pend_issue got %b/%h exp 1/44", bus.br_ren, bus.br_raddr);
      end
      run_bridge(2, 32'hCAFE_0002);
      vectors++;
      if ({bus.req_ack, bus.req_rdata} !== {3'b100, 32'hCAFE_0002}) begin
         miscompares++;
         $display("FAIL pend_ack got %b/%h exp 100/cafe0002", bus.req_ack, bus.req_rdata);
      end
      clear_reqs();
      @(negedge hb_clk);
   endtask

   task automatic test_fairness();
      bit ok;
      logic [7:0] exp_addr;
      logic [2:0] exp_ack;
      for (int i = 0; i < 3; i++) begin
         bus.req_ren[i]   = 1'b1;
         bus.req_raddr[i] = 8'h30 + 8'(i);
      end
      for (int t = 0; t < 6; t++) begin
         wait_issue(ok);
         exp_addr = 8'h30 + 8'(t % 3);
         exp_ack  = 3'b001 << (t % 3);
         vectors++;
         if (!ok || bus.br_raddr !== exp_addr) begin
            miscompares++;
            $display("FAIL fair_grant txn %0d got %b/%h exp 1/%h", t, ok, bus.br_raddr, exp_addr);
         end
         run_bridge(1, 32'h100 + 32'(t));
         vectors++;
         if ({bus.req_ack, bus.req_rdata} !== {exp_ack, 32'h100 + 32'(t)}) begin
            miscompares++;
            $display("FAIL fair_ack txn %0d got %b/%h exp %b/%h", t, bus.req_ack, bus.req_rdata, exp_ack, 32'h100 + 32'(t));
         end
         bus.req_ren[t % 3] = 1'b0;
         @(negedge hb_clk);
         bus.req_ren[t % 3] = 1'b1;
      end
      clear_reqs();
      @(negedge hb_clk);
   endtask

   task automatic test_reset_mid();
      bit ok;
      bus.req_ren[0]   = 1'b1;
      bus.req_raddr[0] = 8'h10;
      wait_issue(ok);
      run_bridge(1, 32'h0000_0011);
      vectors++;
      if (!ok || bus.req_ack !== 3'b001) begin
         miscompares++;
         $display("FAIL rstm_pre got %b/%b exp 1/001", ok, bus.req_ack);
      end
      clear_reqs();
      @(negedge hb_clk);
      bus.req_ren[1]   = 1'b1;
      bus.req_raddr[1] = 8'h99;
      wait_issue(ok);
      bus.br_idle = 1'b0;
      repeat (2) @(negedge hb_clk);
      rst = 1'b1;
      clear_reqs();
      #1;
      vectors++;
      if ({bus.req_ack, bus.req_err, bus.br_ren, bus.br_wen, bus.req_rdata, bus.br_raddr} !== 46'b0) begin
         miscompares++;
         $display("FAIL rstm_outputs got %b/%b/%b%b/%h/%h exp 000/0/00/00000000/00",
                  bus.req_ack, bus.req_err, bus.br_ren, bus.br_wen, bus.req_rdata, bus.br_raddr);
      end
      @(negedge hb_clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.req_ren[i]   = 1'b1;
         bus.req_raddr[i] = 8'hA0 + 8'(i);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge hb_clk);
         vectors++;
         if ({bus.req_ack, bus.br_ren} !== 4'b0) begin
            miscompares++;
            $display("FAIL rstm_drain cyc %0d got %b exp 0000", i, {bus.req_ack, bus.br_ren});
         end
      end
      bus.br_idle = 1'b1;
      wait_issue(ok);
      vectors++;
      if (!ok || bus.br_raddr !== 8'hA0) begin
         miscompares++;
         $display("FAIL rstm_rrptr got %b/%h exp 1/a0", ok, bus.br_raddr);
      end
      run_bridge(1, 32'h0000_1234);
      vectors++;
      if ({bus.req_ack, bus.req_rdata} !== {3'b001, 32'h1234}) begin
         miscompares++;
         $display("FAIL rstm_ack got %b/%h exp 001/00001234", bus.req_ack, bus.req_rdata);
      end
      clear_reqs();
      @(negedge hb_clk);
   endtask

`ifdef XT_LB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      bit early;
      bus.br_idle      = 1'b1;
      bus.req_ren[0]   = 1'b1;
      bus.req_raddr[0] = 8'h5A;
      wait_issue(ok);
      early = 1'b0;
      repeat (9) begin
         @(negedge hb_clk);
         early |= |bus.req_ack;
      end
      vectors++;
      if (!ok || early) begin
         miscompares++;
         $display("FAIL tmo_early got issue=%b early_ack=%b exp 1/0", ok, early);
      end
      @(negedge hb_clk);
      vectors++;
      if ({bus.req_ack, bus.req_err, bus.req_rdata} !== {3'b001, 1'b1, 32'h0}) begin
         miscompares++;
         $display("FAIL tmo_ack got %b/%b/%h exp 001/1/00000000", bus.req_ack, bus.req_err, bus.req_rdata);
      end
      clear_reqs();
      @(negedge hb_clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single_read();
      test_read_write();
      test_pending_bridge();
      test_fairness();
      test_reset_mid();
`ifdef XT_LB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
